// File: rtl/accum_drain.sv
// accum_drain: drains accumulator rows out as a narrow valid/ready beat stream, LSB chunk first
module accum_drain #(
  parameter int VEC_WIDTH  = 384,
  parameter int ARR_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(ARR_DEPTH),
  parameter int OUT_WIDTH  = 128
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_count,
  output logic [ADDR_WIDTH-1:0] o_addr_rd,
  input  logic [VEC_WIDTH-1:0]  i_data_rd,
  output logic                  o_valid,
  output logic [OUT_WIDTH-1:0]  o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int BEATS = VEC_WIDTH / OUT_WIDTH;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2, DONE = 2'd3;
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         count_q, count_d, k_q, k_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [VEC_WIDTH-1:0]  buf_q, buf_d;
  logic                  xfer, last_beat, last_row;
  assign xfer      = state_q == SEND && i_ready;
  assign last_beat = beat_q == BW'(BEATS - 1);
  assign last_row  = k_q == count_q - CW'(1);
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    k_d     = k_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    buf_d   = buf_q;
    if (state_q == IDLE && i_start) begin
      state_d = i_count == '0 ? DONE : LOAD;
      count_d = i_count;
      k_d     = '0;
      beat_d  = '0;
      addr_d  = i_base_addr;
    end
    if (state_q == LOAD) begin
      buf_d   = i_data_rd;
      beat_d  = '0;
      state_d = SEND;
    end
    // the address advances only when a row is fully sent, so it names the row being sent
    if (xfer) begin
      beat_d = last_beat ? '0 : beat_q + BW'(1);
      if (last_beat) begin
        state_d = last_row ? DONE : LOAD;
        k_d     = last_row ? k_q : k_q + CW'(1);
        addr_d  = last_row ? addr_q : addr_q + ADDR_WIDTH'(1);
      end
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      k_q     <= '0;
      addr_q  <= '0;
      beat_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
    end
  end
  assign o_addr_rd = addr_q;
  assign o_valid   = state_q == SEND;
  assign o_data    = buf_q[beat_q*OUT_WIDTH +: OUT_WIDTH];
  assign o_last    = o_valid && last_beat && last_row;
  assign o_busy    = state_q != IDLE;
  assign o_done    = state_q == DONE;
endmodule
